// File: rtl/spi_ahb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_ahb_pkg: shared AHB encodings and sequencer state type         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package spi_ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_LAST = 2'd2,
        S_ERR  = 2'd3
    } seq_state_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    function automatic logic [2:0] calc_hsize(input int unsigned dw);
        logic [2:0] hs;
        hs = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd8 << i) == dw) hs = 3'(i);
        end
        return hs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ahb_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_ahb_wait_timer: counts consecutive hready-low cycles and flags |
// | the cycle in which the limit is reached. Rev 1.0                   |
// +--------------------------------------------------------------------+
module spi_ahb_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic i_en,
    input  logic i_hready,
    output logic o_expired
);
    localparam int unsigned c_CW = $clog2(TIMEOUT_CYC + 1);

    logic [c_CW-1:0] r_cnt;

    // The N-th consecutive wait cycle sees a count of N-1.
    assign o_expired = i_en && !i_hready && (r_cnt == c_CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_cnt <= '0;
        end else if (!i_en || i_hready || o_expired) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/spi_ahb_xfer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_ahb_xfer_sequencer: one SPI command -> AHB-Lite master beats.  |
// | Optional hready watchdog: SPI_AHB_SEQ_TIMEOUT_EN. Rev 1.0          |
// +--------------------------------------------------------------------+
module spi_ahb_xfer_sequencer
    import spi_ahb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [1:0]            htrans,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    input  logic                  hresp,
    input  logic [DATA_WIDTH-1:0] hrdata
);
    localparam int unsigned c_BYTES = DATA_WIDTH / 8;

    seq_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_burst;
    logic [LEN_WIDTH-1:0]  r_left;
    logic                  r_first;
    logic                  r_held;
    logic                  r_dph;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic [DATA_WIDTH-1:0] r_wbuf;

    logic    w_issue;
    logic    w_accept;
    logic    w_nseq;
    logic    w_tmo;
    htrans_e w_htrans;

`ifdef SPI_AHB_SEQ_TIMEOUT_EN
    spi_ahb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .i_en      (r_state != S_IDLE),
        .i_hready  (hready),
        .o_expired (w_tmo)
    );
`else
    assign w_tmo = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    // Once a beat is on the bus (r_held) it stays there regardless of wr_valid.
    assign w_issue  = (r_state == S_ADDR) && (r_held || !r_write || wr_valid);
    assign w_accept = w_issue && hready;
    assign w_nseq   = r_first || (r_addr[9:0] == 10'd0);

    always_comb begin
        w_htrans = HT_IDLE;
        if (!w_tmo && (r_state == S_ADDR)) begin
            if (w_issue)       w_htrans = w_nseq ? HT_NONSEQ : HT_SEQ;
            else if (!r_first) w_htrans = HT_BUSY;
        end
    end

    assign htrans    = w_htrans;
    assign haddr     = r_addr;
    assign hwrite    = r_write;
    assign hburst    = r_burst;
    assign hsize     = calc_hsize(DATA_WIDTH);
    assign hwdata    = r_hwdata;
    assign cmd_ready = (r_state == S_IDLE);
    assign wr_ready  = w_issue && r_write && !r_held && !hresp;
    assign rd_valid  = r_dph && !r_write && hready && !hresp;
    assign rd_data   = hrdata;
    assign done      = (((r_state == S_LAST) || (r_state == S_ERR)) && hready) || w_tmo;
    assign err       = ((r_state == S_ERR) && hready) || w_tmo;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_burst  <= HBURST_SINGLE;
            r_left   <= '0;
            r_first  <= 1'b0;
            r_held   <= 1'b0;
            r_dph    <= 1'b0;
            r_hwdata <= '0;
            r_wbuf   <= '0;
        end else begin
            if (hready) r_dph <= w_accept;

            if (w_accept) begin
                r_addr  <= r_addr + ADDR_WIDTH'(c_BYTES);
                r_first <= 1'b0;
                r_held  <= 1'b0;
                if (r_write) r_hwdata <= r_held ? r_wbuf : wr_data;
            end else if (w_issue && !r_held) begin
                r_held <= 1'b1;
                if (r_write) r_wbuf <= wr_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state <= S_ADDR;
                        r_addr  <= cmd_addr;
                        r_write <= cmd_write;
                        r_left  <= cmd_len;
                        r_burst <= (cmd_len != '0) ? HBURST_INCR : HBURST_SINGLE;
                        r_first <= 1'b1;
                        r_held  <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (w_accept) begin
                        if (r_left == '0) r_state <= S_LAST;
                        else              r_left  <= r_left - 1'b1;
                    end
                end
                S_LAST:  if (hready) r_state <= S_IDLE;
                S_ERR:   if (hready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Abort paths override any progress made above.
            if (w_tmo) begin
                r_state <= S_IDLE;
                r_dph   <= 1'b0;
                r_held  <= 1'b0;
            end else if (r_dph && hresp && !hready) begin
                r_state <= S_ERR;
                r_dph   <= 1'b0;
                r_held  <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_ahb_xfer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_ahb_xfer_sequencer: directed checks of the SPI->AHB         |
// | sequencer (SPI_AHB_SEQ_TIMEOUT_EN adds the watchdog case). Rev 1.0 |
// +--------------------------------------------------------------------+
module tb_spi_ahb_xfer_sequencer;
    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;

    int n_chk = 0;
    int n_bad = 0;

    spi_ahb_xfer_sequencer #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .LEN_WIDTH   (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offers a command for one cycle; returns at the negedge of the first address cycle.
    task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
        @(negedge hclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        #1;
        chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        @(negedge hclk);
        cmd_valid = 1'b0;
    endtask

    int n_rd;
    int done_cyc;

    initial begin
        // Reset state
        @(negedge hclk); #1;
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_haddr", 64'(haddr), 64'd0);
        chk("rst_hwrite", 64'(hwrite), 64'd0);
        chk("rst_hburst", 64'(hburst), 64'd0);
        chk("rst_hwdata", 64'(hwdata), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_outs", 64'({wr_ready, rd_valid, done, err}), 64'd0);
        chk("hsize", 64'(hsize), 64'd2);
        hresetn = 1'b1;

        // Single read at 0x100
        issue_cmd(1'b0, 32'h100, 8'd0);
        #1;
        chk("rd1_htrans", 64'(htrans), 64'd2);
        chk("rd1_haddr", 64'(haddr), 64'h100);
        chk("rd1_hburst", 64'(hburst), 64'd0);
        chk("rd1_busy_ready", 64'(cmd_ready), 64'd0);
        @(negedge hclk); hrdata = 32'hCAFE_0001; #1;
        chk("rd1_rd_valid", 64'(rd_valid), 64'd1);
        chk("rd1_rd_data", 64'(rd_data), 64'hCAFE_0001);
        chk("rd1_done_err", 64'({done, err}), 64'b10);
        chk("rd1_htrans_last", 64'(htrans), 64'd0);
        @(negedge hclk); hrdata = '0; #1;
        chk("rd1_ready_back", 64'({cmd_ready, done}), 64'b10);

        // Write burst len=3 at 0x40 with continuous data
        wr_valid = 1'b1; wr_data = 32'hA0;
        issue_cmd(1'b1, 32'h40, 8'd3);
        #1;
        chk("wr4_b0", 64'({htrans, haddr, wr_ready}), 64'({2'd2, 32'h40, 1'b1}));
        chk("wr4_hburst_hwrite", 64'({hburst, hwrite}), 64'({3'd1, 1'b1}));
        @(negedge hclk); wr_data = 32'hA1; #1;
        chk("wr4_b1", 64'({htrans, haddr, hwdata}), 64'({2'd3, 32'h44, 32'hA0}));
        @(negedge hclk); wr_data = 32'hA2; #1;
        chk("wr4_b2", 64'({htrans, haddr, hwdata}), 64'({2'd3, 32'h48, 32'hA1}));
        @(negedge hclk); wr_data = 32'hA3; #1;
        chk("wr4_b3", 64'({htrans, haddr, hwdata}), 64'({2'd3, 32'h4C, 32'hA2}));
        @(negedge hclk); wr_valid = 1'b0; #1;
        chk("wr4_last_data", 64'(hwdata), 64'hA3);
        chk("wr4_done", 64'({done, err, wr_ready, htrans}), 64'({1'b1, 1'b0, 1'b0, 2'd0}));

        // Write burst with two BUSY cycles after beat 0
        wr_valid = 1'b1; wr_data = 32'hE0;
        issue_cmd(1'b1, 32'h40, 8'd3);
        #1;
        chk("busy_b0", 64'({htrans, haddr, wr_ready}), 64'({2'd2, 32'h40, 1'b1}));
        @(negedge hclk); wr_valid = 1'b0; #1;
        chk("busy_c1", 64'({htrans, haddr, hwdata, wr_ready}), 64'({2'd1, 32'h44, 32'hE0, 1'b0}));
        @(negedge hclk); #1;
        chk("busy_c2", 64'({htrans, haddr}), 64'({2'd1, 32'h44}));
        @(negedge hclk); wr_valid = 1'b1; wr_data = 32'hE1; #1;
        chk("busy_resume", 64'({htrans, haddr, wr_ready}), 64'({2'd3, 32'h44, 1'b1}));
        @(negedge hclk); wr_data = 32'hE2; #1;
        chk("busy_b2", 64'({htrans, haddr, hwdata}), 64'({2'd3, 32'h48, 32'hE1}));
        @(negedge hclk); wr_data = 32'hE3; #1;
        chk("busy_b3", 64'({htrans, haddr, hwdata}), 64'({2'd3, 32'h4C, 32'hE2}));
        @(negedge hclk); wr_valid = 1'b0; #1;
        chk("busy_end", 64'({hwdata, done, err}), 64'({32'hE3, 1'b1, 1'b0}));

        // First write beat waits for data; last data phase stretched by hready
        issue_cmd(1'b1, 32'h10, 8'd0);
        #1;
        chk("wfirst_idle", 64'({htrans, wr_ready}), 64'({2'd0, 1'b0}));
        @(negedge hclk); #1;
        chk("wfirst_idle2", 64'(htrans), 64'd0);
        @(negedge hclk); wr_valid = 1'b1; wr_data = 32'h5A5A_0010; #1;
        chk("wfirst_go", 64'({htrans, haddr, wr_ready}), 64'({2'd2, 32'h10, 1'b1}));
        @(negedge hclk); wr_valid = 1'b0; hready = 1'b0; #1;
        chk("wfirst_wait", 64'({hwdata, done}), 64'({32'h5A5A_0010, 1'b0}));
        @(negedge hclk); hready = 1'b1; #1;
        chk("wfirst_done", 64'({hwdata, done}), 64'({32'h5A5A_0010, 1'b1}));

        // Read across the 1KB boundary
        issue_cmd(1'b0, 32'h3FC, 8'd1);
        #1;
        chk("kb_b0", 64'({htrans, haddr}), 64'({2'd2, 32'h3FC}));
        @(negedge hclk); hrdata = 32'h1111_0000; #1;
        chk("kb_b1", 64'({htrans, haddr, rd_valid, rd_data}), 64'({2'd2, 32'h400, 1'b1, 32'h1111_0000}));
        @(negedge hclk); hrdata = 32'h2222_0000; #1;
        chk("kb_end", 64'({rd_valid, rd_data, done}), 64'({1'b1, 32'h2222_0000, 1'b1}));

        // Error response on beat 2 of 4; a second command offered meanwhile is ignored
        issue_cmd(1'b0, 32'h200, 8'd3);
        cmd_valid = 1'b1; cmd_addr = 32'h700; #1;
        chk("err_cmd_blocked", 64'(cmd_ready), 64'd0);
        @(negedge hclk); cmd_valid = 1'b0; hrdata = 32'h0000_0200; #1;
        chk("err_b0_data", 64'({htrans, haddr, rd_valid}), 64'({2'd3, 32'h204, 1'b1}));
        @(negedge hclk); hresp = 1'b1; hready = 1'b0; #1;
        chk("err_cyc1", 64'({htrans, haddr, rd_valid, done}), 64'({2'd3, 32'h208, 1'b0, 1'b0}));
        @(negedge hclk); hready = 1'b1; #1;
        chk("err_cyc2", 64'({htrans, done, err, rd_valid}), 64'({2'd0, 1'b1, 1'b1, 1'b0}));
        @(negedge hclk); hresp = 1'b0; #1;
        chk("err_after", 64'({cmd_ready, done, err, htrans}), 64'({1'b1, 1'b0, 1'b0, 2'd0}));

        // Reset during beat 2 of a write burst
        wr_valid = 1'b1; wr_data = 32'hF0;
        issue_cmd(1'b1, 32'h40, 8'd3);
        @(negedge hclk); wr_data = 32'hF1; #1;
        chk("rstmid_pre", 64'({htrans, haddr, hwdata}), 64'({2'd3, 32'h44, 32'hF0}));
        hresetn = 1'b0; #1;
        chk("rstmid_bus", 64'({htrans, haddr, hwrite, hburst, hwdata}), 64'd0);
        chk("rstmid_ctl", 64'({cmd_ready, wr_ready, rd_valid, done, err}), 64'b10000);
        @(negedge hclk); wr_valid = 1'b0; hresetn = 1'b1; #1;
        chk("rstmid_nodone", 64'({done, htrans, cmd_ready}), 64'({1'b0, 2'd0, 1'b1}));

        // Maximum length read: 256 beats, done only after the last data phase
        hrdata = 32'h0BAD_F00D;
        issue_cmd(1'b0, 32'h0, 8'hFF);
        n_rd = 0; done_cyc = 0;
        #1;
        for (int i = 1; i <= 300 && done_cyc == 0; i++) begin
            if (i > 1) begin @(negedge hclk); #1; end
            if (rd_valid) n_rd++;
            if (done) done_cyc = i;
        end
        chk("max_rd_count", 64'(n_rd), 64'd256);
        chk("max_done_cycle", 64'(done_cyc), 64'd257);

`ifdef SPI_AHB_SEQ_TIMEOUT_EN
        // Watchdog: hready stuck low from the first address phase
        issue_cmd(1'b0, 32'h20, 8'd0);
        hready = 1'b0;
        done_cyc = 0;
        #1;
        for (int i = 1; i <= 40 && done_cyc == 0; i++) begin
            if (i > 1) begin @(negedge hclk); #1; end
            if (done) begin
                done_cyc = i;
                chk("tmo_err_htrans", 64'({err, htrans}), 64'({1'b1, 2'd0}));
            end
        end
        chk("tmo_cycle", 64'(done_cyc), 64'd16);
        @(negedge hclk); hready = 1'b1; #1;
        chk("tmo_ready_back", 64'(cmd_ready), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
